// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider with glitch-free registered output,
// per-period tick, and a valid/ready ratio update applied on period boundaries.
module clock_divider_prog #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned RESET_DIV    = 4,
   parameter bit          RESET_EN_RUN = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_en,
   input  logic [CNT_W-1:0] io_div,
   input  logic             io_div_valid,
   output logic             io_div_ready,
   output logic             io_div_err,
   output logic [CNT_W-1:0] io_ratio,
   output logic             io_clock_out,
   output logic             io_tick,
   output logic             io_busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [CNT_W-1:0] RESET_RATIO = CNT_W'(RESET_DIV);
   localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

   generate
      if ((CNT_W < 2) || (CNT_W > 16)) begin : g_bad_cnt_w
         $error("clock_divider_prog: CNT_W must be in 2..16");
      end
      if ((RESET_DIV < 2) || (RESET_DIV > ((1 << CNT_W) - 1))) begin : g_bad_reset_div
         $error("clock_divider_prog: RESET_DIV must be in [2, 2^CNT_W-1]");
      end
   endgenerate

   logic [1:0]       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] ratio_q,    ratio_d;
   logic [CNT_W-1:0] pend_q,     pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_out_q,  clk_out_d;
   logic             tick_q,     tick_d;
   logic             err_q,      err_d;
   logic             start_q,    start_d;

   logic [CNT_W-1:0] half_hi;
   logic [CNT_W-1:0] half_lo;
   logic             hi_last;
   logic             lo_last;
   logic             accept;
   logic             div_bad;
   logic             accept_ok;

   // Odd ratios put the extra cycle in the high phase.
   always_comb begin
      half_lo   = ratio_q >> 1;
      half_hi   = ratio_q - half_lo;
      hi_last   = (cnt_q == (half_hi - ONE));
      lo_last   = (cnt_q == (half_lo - ONE));
      accept    = io_div_valid && !pend_vld_q;
      div_bad   = (io_div[CNT_W-1:1] == '0);
      accept_ok = accept && !div_bad;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ratio_d    = ratio_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      err_d      = accept && div_bad;
      start_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_out_d = 1'b0;
            cnt_d     = '0;
            if (accept_ok) begin
               ratio_d = io_div;
            end
            if (io_en || start_q) begin
               state_d   = ST_HIGH;
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
            end
         end

         ST_HIGH: begin
            if (hi_last) begin
               state_d   = ST_LOW;
               clk_out_d = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
            if (accept_ok) begin
               pend_d     = io_div;
               pend_vld_d = 1'b1;
            end
         end

         ST_LOW: begin
            if (lo_last) begin
               // Boundary: a same-cycle request bypasses the pending slot.
               if (accept_ok) begin
                  ratio_d = io_div;
               end else if (pend_vld_q) begin
                  ratio_d = pend_q;
               end
               pend_vld_d = 1'b0;
               cnt_d      = '0;
               if (io_en) begin
                  state_d   = ST_HIGH;
                  clk_out_d = 1'b1;
                  tick_d    = 1'b1;
               end else begin
                  state_d   = ST_IDLE;
                  clk_out_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + ONE;
               if (accept_ok) begin
                  pend_d     = io_div;
                  pend_vld_d = 1'b1;
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_out_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ratio_q    <= RESET_RATIO;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= RESET_EN_RUN;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ratio_q    <= ratio_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
         start_q    <= start_d;
      end
   end

   assign io_div_ready = !pend_vld_q;
   assign io_div_err   = err_q;
   assign io_ratio     = ratio_q;
   assign io_clock_out = clk_out_q;
   assign io_tick      = tick_q;
   assign io_busy      = (state_q != ST_IDLE);

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Programmable integer clock divider: the generalised successor to the fixed divide-by-4 chain of ripple divide-by-2 stages.
- Produces a registered, glitch-free divided clock of any ratio N in [2, 2^CNT_W-1], plus a one-cycle tick at each output rising edge.
- Ratio is changed at run time through a valid/ready handshake and takes effect only on period boundaries.
- Sits in the testbench/clock-generation area, feeding slow peripheral and RTC-style clock domains from the core clock.

Parameters:
- CNT_W, 8, width of the ratio and of the phase counter; legal range 2..16.
- RESET_DIV, 4, ratio loaded at reset; must be in [2, 2^CNT_W-1] (elaboration-time assertion).
- RESET_EN_RUN, 0, 1 = divider starts running out of reset without waiting for io_en.

Ports:
- clock  in  1  source clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_en  in  1  run request; sampled every cycle.
- io_div  in  CNT_W  requested ratio N.
- io_div_valid  in  1  io_div is valid.
- io_div_ready  out  1  divider can accept a new ratio.
- io_div_err  out  1  one-cycle pulse: accepted request had N<2 and was discarded.
- io_ratio  out  CNT_W  ratio currently in effect.
- io_clock_out  out  1  divided clock, driven directly from a flop.
- io_tick  out  1  one-cycle pulse in the first cycle io_clock_out is high.
- io_busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, io_clock_out=0, io_tick=0, io_div_err=0, io_ratio=RESET_DIV, pending register empty, io_div_ready=1, cnt=0. With RESET_EN_RUN=1 the divider enters HIGH in the first cycle after reset deasserts, whatever io_en is in that cycle. Reset asserted mid-period aborts immediately; no completion of the period.
- Phase split: H = N - (N>>1) and L = N>>1. High phase lasts ceil(N/2) cycles and low phase floor(N/2) cycles. Example: N=5 gives H=3, L=2.
- States: IDLE, HIGH, LOW.
  - IDLE: io_clock_out=0. If io_en=1, the next cycle is HIGH with io_clock_out=1, io_tick=1, cnt=0. Latency from io_en rise to io_clock_out rise is 1 cycle.
  - HIGH: cnt increments each cycle. When cnt==H-1, the next cycle is LOW with io_clock_out=0 and cnt=0.
  - LOW: when cnt==L-1 the cycle is a period boundary. At the boundary, load the pending ratio if present. Then, if io_en=1, go to HIGH with io_clock_out=1, io_tick=1, cnt=0; otherwise go to IDLE.
- io_en deassertion takes effect only at a period boundary. The current period always completes, so there are no runt pulses.
- Handshake:
  - A transfer occurs when io_div_valid && io_div_ready. io_div_ready = !pending.
  - In IDLE, an accepted ratio becomes io_ratio on the next cycle; pending is not used.
  - In HIGH/LOW, an accepted ratio is stored as pending and io_div_ready drops. At the next boundary the pending value moves into io_ratio and io_div_ready returns to 1 on the cycle after the boundary.
  - Acceptance in the boundary cycle itself bypasses pending: the period starting on the next cycle already uses the new N.
  - An accepted N of 0 or 1 is discarded: io_div_err=1 for one cycle, io_ratio and pending are unchanged, and io_div_ready is unaffected.
- io_ratio never changes except at a boundary or from IDLE. H and L are recomputed only from io_ratio.
- Widths: cnt is CNT_W bits, H is at most 2^(CNT_W-1), and there is no overflow. All arithmetic is unsigned.
- io_clock_out and io_tick are flop outputs with no combinational path from inputs.

Test Plan:
- Reset with defaults, then io_en=1 -> from 1 cycle later io_clock_out repeats 1,1,0,0; io_tick every 4 cycles; io_ratio=4; io_busy=1.
- Load N=5 in IDLE, then enable -> io_clock_out repeats 1,1,1,0,0; io_tick period 5.
- Running at N=4, present N=6 in the 2nd high cycle -> current period finishes its 4 cycles; io_div_ready=0 until the boundary; next periods 1,1,1,0,0,0; io_ratio changes to 6 at the boundary.
- Present N=6 exactly in a boundary cycle -> the very next period is 3 high / 3 low; io_div_ready stays 1.
- Present N=1, then N=0 -> io_div_err pulses once each; io_ratio unchanged; waveform unchanged.
- Drop io_en during the 1st high cycle at N=8 -> 4 high and 4 low cycles complete, then IDLE with io_clock_out=0 and io_busy=0.
- Assert reset mid-HIGH at N=255 -> next cycle io_clock_out=0, io_ratio=4, IDLE. Then N=255 run -> 128 high, 127 low.
